// File: rtl/pump_ctrl_pkg.sv
// Shared state encoding, level width and default thresholds/timings for the drainage pump controller.
package pump_ctrl_pkg;

   localparam int LVL_W     = 4;
   localparam int DEF_CNT_W = 32;

   typedef logic [LVL_W-1:0] lvl_t;

   typedef enum logic [1:0] {
      S_IDLE  = 2'd0,
      S_RUN   = 2'd1,
      S_COOL  = 2'd2,
      S_FAULT = 2'd3
   } state_t;

   localparam lvl_t DEF_HIGH_TH  = 4'd10;
   localparam lvl_t DEF_LOW_TH   = 4'd4;
   localparam lvl_t DEF_ALARM_TH = 4'd13;

   // 50 MHz system clock
   localparam int unsigned DEF_MIN_RUN  = 50_000_000;
   localparam int unsigned DEF_COOLDOWN = 25_000_000;
   localparam int unsigned DEF_MAX_RUN  = 500_000_000;

endpackage

// File: rtl/pump_ctrl_fsm_if.sv
// Level/button inputs and pump/LED status outputs of the pump controller.
interface pump_ctrl_fsm_if;
   import pump_ctrl_pkg::*;

   logic       level_valid;
   lvl_t       level;
   logic       manual_press;
   logic       pump_on;
   logic       alarm;
   logic       fault;
   logic [1:0] state;

   modport master (output level_valid, level, manual_press,
                   input  pump_on, alarm, fault, state);
   modport slave  (input  level_valid, level, manual_press,
                   output pump_on, alarm, fault, state);
endinterface

// File: rtl/pump_timer.sv
// Saturating clear/enable up-counter with a ">= limit" compare, shared by the run and cooldown phases.
module pump_timer #(
   parameter int CNT_W = 32
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             clr,
   input  logic             en,
   input  logic [CNT_W-1:0] limit,
   output logic             hit
);
   logic [CNT_W-1:0] cnt;

   always_ff @(posedge clk) begin
      if (rst || clr)
         cnt <= '0;
      else if (en && (cnt != '1))
         cnt <= cnt + 1'b1;
   end

   assign hit = (cnt >= limit);
endmodule

// File: rtl/pump_ctrl_fsm.sv
// Drainage pump sequencer: hysteretic auto mode, manual start/stop, min-run, cooldown and high-water alarm.
// Define PUMP_WATCHDOG_EN to add the over-long-run FAULT state.
module pump_ctrl_fsm
   import pump_ctrl_pkg::*;
#(
   parameter lvl_t        HIGH_TH  = DEF_HIGH_TH,
   parameter lvl_t        LOW_TH   = DEF_LOW_TH,
   parameter lvl_t        ALARM_TH = DEF_ALARM_TH,
   parameter int unsigned MIN_RUN  = DEF_MIN_RUN,
   parameter int unsigned COOLDOWN = DEF_COOLDOWN,
   parameter int unsigned MAX_RUN  = DEF_MAX_RUN,
   parameter int          CNT_W    = DEF_CNT_W
) (
   input logic            clk,
   input logic            rst,
   pump_ctrl_fsm_if.slave bus
);
   localparam logic [CNT_W-1:0] MIN_LIM  = CNT_W'(MIN_RUN - 1);
   localparam logic [CNT_W-1:0] COOL_LIM = CNT_W'(COOLDOWN - 1);
   localparam longint unsigned  CNT_MAX  = (64'd1 << CNT_W) - 64'd1;

   if (LOW_TH >= HIGH_TH || MIN_RUN == 0 || COOLDOWN == 0 ||
       64'(MIN_RUN) > CNT_MAX || 64'(COOLDOWN) > CNT_MAX || 64'(MAX_RUN) > CNT_MAX) begin : g_bad_cfg
      $error("pump_ctrl_fsm: invalid threshold/timer parameters");
   end

   state_t           st, nxt;
   lvl_t             lvl_q, cur_lvl;
   logic             manual, stop_req, pump_q, alarm_q;
   logic             hi_lvl, lo_lvl, al_lvl;
   logic             tmr_clr, tmr_en, hit;
   logic [CNT_W-1:0] lim;

   // A fresh sample acts in the cycle it arrives
   assign cur_lvl = bus.level_valid ? bus.level : lvl_q;
   assign hi_lvl  = (cur_lvl >= HIGH_TH);
   assign lo_lvl  = (cur_lvl <= LOW_TH);
   assign al_lvl  = (cur_lvl >= ALARM_TH);

   assign lim     = (st == S_COOL) ? COOL_LIM : MIN_LIM;
   assign tmr_clr = (nxt != st) || (st == S_IDLE);
   assign tmr_en  = (st == S_RUN) || (st == S_COOL);

   pump_timer #(.CNT_W(CNT_W)) u_timer (
      .clk(clk), .rst(rst), .clr(tmr_clr), .en(tmr_en), .limit(lim), .hit(hit)
   );

`ifdef PUMP_WATCHDOG_EN
   localparam logic [CNT_W-1:0] MAX_LIM = CNT_W'(MAX_RUN - 1);
   logic wd_hit, fault_q;

   pump_timer #(.CNT_W(CNT_W)) u_wd_timer (
      .clk(clk), .rst(rst), .clr(tmr_clr), .en(tmr_en), .limit(MAX_LIM), .hit(wd_hit)
   );
`endif

   always_comb begin
      nxt = st;
      case (st)
         S_RUN: begin
`ifdef PUMP_WATCHDOG_EN
            if (wd_hit && !lo_lvl) nxt = S_FAULT;
            else
`endif
            // An alarm-level reading keeps the pump running whatever stop is pending
            if (hit && !al_lvl && (stop_req || (!manual && lo_lvl))) nxt = S_COOL;
         end
         S_COOL: begin
            if (al_lvl)   nxt = S_RUN;
            else if (hit) nxt = S_IDLE;
         end
`ifdef PUMP_WATCHDOG_EN
         S_FAULT: nxt = S_FAULT;
`endif
         default: begin
            if (bus.manual_press || hi_lvl) nxt = S_RUN;
         end
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         st       <= S_IDLE;
         pump_q   <= 1'b0;
         alarm_q  <= 1'b0;
         lvl_q    <= '0;
         manual   <= 1'b0;
         stop_req <= 1'b0;
`ifdef PUMP_WATCHDOG_EN
         fault_q  <= 1'b0;
`endif
      end else begin
         if (bus.level_valid) lvl_q <= bus.level;
         alarm_q <= al_lvl;
         st      <= nxt;
         pump_q  <= (nxt == S_RUN);
`ifdef PUMP_WATCHDOG_EN
         fault_q <= (nxt == S_FAULT);
`endif
         case (st)
            S_RUN: begin
               if (nxt != S_RUN) begin
                  manual   <= 1'b0;
                  stop_req <= 1'b0;
               end else if (bus.manual_press) begin
                  stop_req <= 1'b1;
               end
            end
            S_COOL: begin
               manual   <= 1'b0;
               stop_req <= 1'b0;
            end
            default: begin
               // A press in IDLE always starts in manual mode, even with high water
               manual   <= bus.manual_press;
               stop_req <= 1'b0;
            end
         endcase
      end
   end

   assign bus.state   = st;
   assign bus.pump_on = pump_q;
   assign bus.alarm   = alarm_q;
`ifdef PUMP_WATCHDOG_EN
   assign bus.fault   = fault_q;
`else
   assign bus.fault   = 1'b0;
`endif
endmodule
